btn_debounce_repeat: RTL and testbench



---
 rtl/btn_debounce_repeat.sv | 182 ++++++++++++++++++
 tb/tb_btn_debounce_repeat.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_repeat.sv
//==============================================================================
// Module      : btn_debounce_repeat
// Description : Navigation push-button conditioner. Each button passes through
//               optional polarity inversion, a 2-FF synchronizer and a
//               stable-count debouncer. It then produces registered
//               press/release pulses, with auto-repeat on held buttons whose
//               REPEAT_MASK bit is set.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module btn_debounce_repeat #(
    parameter int                 NUM_BTN      = 5,
    parameter int                 DEBOUNCE_CYC = 330000,
    parameter int                 REPEAT_DLY   = 16500000,
    parameter int                 REPEAT_PER   = 3300000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK  = 5'b01111,
    parameter bit                 ACTIVE_LOW   = 1'b0
) (
    input  logic               lcd_clk_33m,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               btn_any
);

    // Debounce counter only needs to reach DEBOUNCE_CYC-1 before it returns to 0
    localparam int C_CNT_W     = ($clog2(DEBOUNCE_CYC) > 0) ? $clog2(DEBOUNCE_CYC) : 1;
    // One repeat timer serves both the initial delay and the period
    localparam int C_RPT_MAX   = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int C_TMR_W     = ($clog2(C_RPT_MAX) > 0) ? $clog2(C_RPT_MAX) : 1;

    localparam logic [C_CNT_W-1:0] C_DB_LAST  = C_CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [C_TMR_W-1:0] C_DLY_LAST = C_TMR_W'(REPEAT_DLY - 1);
    localparam logic [C_TMR_W-1:0] C_PER_LAST = C_TMR_W'(REPEAT_PER - 1);

    // Per-button repeat state machine encoding
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2,
        S_HELD   = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] w_raw;        // polarity-corrected raw pins, 1 = pressed
    logic [NUM_BTN-1:0] w_press_evt;  // press pulse to be registered this edge
    logic               r_any;

    // Fold the pin polarity in before synchronization so everything downstream is active-high
    if (ACTIVE_LOW) begin : g_pol_inv
        assign w_raw = ~btn_raw;
    end else begin : g_pol_pass
        assign w_raw = btn_raw;
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_stable;
        logic               r_stable_d;
        logic [C_CNT_W-1:0] r_db_cnt;
        logic [C_TMR_W-1:0] r_timer;
        state_t             r_state;
        logic               r_press;
        logic               r_release;

        logic               w_rise;
        logic               w_fall;
        logic               w_dly_done;
        logic               w_per_done;

        // Two-stage synchronizer for the asynchronous pin
        always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= w_raw[i];
                r_sync2 <= r_sync1;
            end
        end

        // Accept a new level only after DEBOUNCE_CYC consecutive disagreeing cycles
        always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
            if (!rst_n) begin
                r_db_cnt   <= '0;
                r_stable   <= 1'b0;
                r_stable_d <= 1'b0;
            end else begin
                r_stable_d <= r_stable;
                if (r_sync2 == r_stable) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == C_DB_LAST) begin
                    r_stable <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        assign w_rise     = r_stable & ~r_stable_d;
        assign w_fall     = ~r_stable & r_stable_d;
        assign w_dly_done = (r_timer == C_DLY_LAST);
        assign w_per_done = (r_timer == C_PER_LAST);

        // A release always wins, so a repeat that coincides with it is dropped
        assign w_press_evt[i] = ~w_fall &
                                (((r_state == S_IDLE)   & w_rise)     |
                                 ((r_state == S_DELAY)  & w_dly_done) |
                                 ((r_state == S_REPEAT) & w_per_done));

        // Repeat state machine with registered press/release pulses
        always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= S_IDLE;
                r_timer   <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_press_evt[i];
                r_release <= w_fall;
                if (w_fall) begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            r_timer <= '0;
                            if (w_rise) begin
                                r_state <= REPEAT_MASK[i] ? S_DELAY : S_HELD;
                            end
                        end
                        S_DELAY: begin
                            if (w_dly_done) begin
                                r_state <= S_REPEAT;
                                r_timer <= '0;
                            end else begin
                                r_timer <= r_timer + 1'b1;
                            end
                        end
                        S_REPEAT: begin
                            if (w_per_done) begin
                                r_timer <= '0;
                            end else begin
                                r_timer <= r_timer + 1'b1;
                            end
                        end
                        S_HELD: begin
                            r_timer <= '0;
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_timer <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[i]   = r_stable;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;
    end

    // Summary flag registered alongside the individual press pulses
    always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_press_evt;
        end
    end

    assign btn_any = r_any;

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_repeat.sv
//==============================================================================
// Module      : tb_btn_debounce_repeat
// Description : Directed bench for btn_debounce_repeat with short debounce and
//               repeat timing; expected values are hand-derived edge counts.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_btn_debounce_repeat;

    localparam int C_NUM = 5;

    logic             lcd_clk_33m = 1'b0;
    logic             rst_n;
    logic [C_NUM-1:0] btn_raw;
    logic [C_NUM-1:0] btn_level;
    logic [C_NUM-1:0] btn_press;
    logic [C_NUM-1:0] btn_release;
    logic             btn_any;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse / level occupancy counters, sampled on the falling edge
    int press_cnt [C_NUM] = '{0, 0, 0, 0, 0};
    int rel_cnt   [C_NUM] = '{0, 0, 0, 0, 0};
    int lvl_cnt   [C_NUM] = '{0, 0, 0, 0, 0};

    int snap_p;
    int snap_r;
    int snap_l;

    btn_debounce_repeat #(
        .NUM_BTN      (C_NUM),
        .DEBOUNCE_CYC (4),
        .REPEAT_DLY   (20),
        .REPEAT_PER   (8),
        .REPEAT_MASK  (5'b01111),
        .ACTIVE_LOW   (1'b0)
    ) u_dut (
        .lcd_clk_33m (lcd_clk_33m),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_any     (btn_any)
    );

    always #15 lcd_clk_33m = ~lcd_clk_33m;

    always @(negedge lcd_clk_33m) begin
        for (int b = 0; b < C_NUM; b++) begin
            if (btn_press[b])   press_cnt[b] <= press_cnt[b] + 1;
            if (btn_release[b]) rel_cnt[b]   <= rel_cnt[b] + 1;
            if (btn_level[b])   lvl_cnt[b]   <= lvl_cnt[b] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge lcd_clk_33m);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    initial begin
        // ---- reset with all buttons held ----
        rst_n   = 1'b0;
        btn_raw = 5'b11111;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("rst_outs_zero", {btn_level, btn_press, btn_release, btn_any}, 32'h0);
        end
        rst_n = 1'b1;                       // next edge is R
        tick(5);
        check("rst_level_early", btn_level, 32'h00);
        tick(1);                            // after R+5
        check("rst_level", btn_level, 32'h1f);
        check("rst_press_early", btn_press, 32'h00);
        tick(1);                            // after R+6
        check("rst_press", btn_press, 32'h1f);
        check("rst_any", btn_any, 32'h1);
        tick(1);
        check("rst_press_width", {btn_press, btn_any}, 32'h0);
        tick(19);                           // after R+26: first repeat, center excluded
        check("rst_repeat_mask", btn_press, 32'h0f);
        btn_raw = 5'b00000;                 // sampled at R+27
        tick(6);
        check("rst_release_early", btn_release, 32'h00);
        tick(1);
        check("rst_release", btn_release, 32'h1f);
        snap_p = press_cnt[0];
        tick(10);
        check("rst_no_press_after_rel", press_cnt[0] - snap_p, 32'd0);
        check("rst_center_presses", press_cnt[4], 32'd1);
        check("rst_up_presses", press_cnt[0], 32'd2);

        // ---- single short press on up ----
        snap_p = press_cnt[0];
        snap_r = rel_cnt[0];
        btn_raw = 5'b00001;                 // sampled at E
        tick(5);
        check("up_level_early", btn_level, 32'h00);
        tick(1);
        check("up_level", btn_level, 32'h01);
        tick(1);
        check("up_press", btn_press, 32'h01);
        check("up_any", btn_any, 32'h1);
        tick(1);
        check("up_press_width", btn_press, 32'h00);
        tick(2);
        btn_raw = 5'b00000;
        tick(12);
        check("up_press_count", press_cnt[0] - snap_p, 32'd1);
        check("up_release_count", rel_cnt[0] - snap_r, 32'd1);

        // ---- bouncing down button ----
        snap_p = press_cnt[1];
        snap_r = rel_cnt[1];
        snap_l = lvl_cnt[1];
        for (int k = 0; k < 40; k++) begin
            btn_raw = {3'b000, ((k % 4) != 3), 1'b0};
            tick(1);
        end
        btn_raw = 5'b00000;
        tick(8);
        check("bounce_level", lvl_cnt[1] - snap_l, 32'd0);
        check("bounce_press", press_cnt[1] - snap_p, 32'd0);
        check("bounce_release", rel_cnt[1] - snap_r, 32'd0);

        // ---- long hold on left: auto-repeat ----
        snap_p = press_cnt[2];
        snap_r = rel_cnt[2];
        btn_raw = 5'b00100;                 // sampled at E
        tick(7);
        check("left_press_P", btn_press, 32'h04);
        tick(19);
        check("left_no_early_rpt", btn_press, 32'h00);
        tick(1);
        check("left_rpt_P20", btn_press, 32'h04);
        tick(8);
        check("left_rpt_P28", btn_press, 32'h04);
        tick(8);
        check("left_rpt_P36", btn_press, 32'h04);
        tick(37);                           // after E+79
        btn_raw = 5'b00000;
        tick(6);
        check("left_release_early", btn_release, 32'h00);
        tick(1);
        check("left_release", btn_release, 32'h04);
        tick(12);
        check("left_press_count", press_cnt[2] - snap_p, 32'd9);
        check("left_release_count", rel_cnt[2] - snap_r, 32'd1);

        // ---- long hold on center: no repeat ----
        snap_p = press_cnt[4];
        snap_r = rel_cnt[4];
        btn_raw = 5'b10000;
        tick(7);
        check("center_press", btn_press, 32'h10);
        tick(92);                           // after E+98
        btn_raw = 5'b00000;
        tick(6);
        check("center_release_early", btn_release, 32'h00);
        tick(1);
        check("center_release", btn_release, 32'h10);
        tick(10);
        check("center_press_count", press_cnt[4] - snap_p, 32'd1);
        check("center_release_count", rel_cnt[4] - snap_r, 32'd1);

        // ---- reset in the middle of a repeating hold on right ----
        snap_p = press_cnt[3];
        btn_raw = 5'b01000;
        tick(7);
        check("right_press", btn_press, 32'h08);
        tick(20);
        check("right_rpt", btn_press, 32'h08);
        tick(4);
        snap_p = press_cnt[3];
        snap_r = rel_cnt[3];
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("midrst_outs_zero", {btn_level, btn_press, btn_release, btn_any}, 32'h0);
        end
        rst_n = 1'b1;                       // next edge is R
        tick(5);
        check("midrst_level_early", btn_level, 32'h00);
        tick(1);
        check("midrst_level", btn_level, 32'h08);
        check("midrst_no_release", rel_cnt[3] - snap_r, 32'd0);
        tick(1);
        check("midrst_press", btn_press, 32'h08);
        tick(19);
        check("midrst_no_early_rpt", btn_press, 32'h00);
        tick(1);
        check("midrst_rpt_20", btn_press, 32'h08);
        tick(8);
        check("midrst_rpt_28", btn_press, 32'h08);
        btn_raw = 5'b00000;
        tick(15);
        check("midrst_press_count", press_cnt[3] - snap_p, 32'd3);
        check("midrst_release_count", rel_cnt[3] - snap_r, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
